fifo_skew_ctrl: RTL and testbench

- Read scheduler for a bank of ROWS row FIFOs (8-deep, 32-bit, combinational read data) feeding the systolic array's west edge.
- Issues per-row read strobes with the diagonal skew the array needs: row r starts r steps after row 0.
- Stalls the whole wavefront when any due FIFO is empty or the array is not ready.
- Reports busy, done and stall statistics to the top-level sequencer.

---
 rtl/tpu_ctrl_pkg.sv | 28 ++
 rtl/fifo_skew_ctrl.sv | 97 +++++++++
 tb/tb_fifo_skew_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : tpu_ctrl_pkg
// Brief  : Shared types and sizing helpers for the array control blocks.
// Rev    : 1.0
// ============================================================================
package tpu_ctrl_pkg;

    localparam int ROWS_DEF  = 4;
    localparam int LEN_W_DEF = 8;

    // Highest value the skew step counter, or a row's end bound, can reach.
    localparam int STEPS_MAX = 2**LEN_W_DEF + ROWS_DEF - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int step_w(input int len_w, input int rows);
        int w;
        w = $clog2(2**len_w + rows - 1);
        return (w > len_w) ? w : len_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_skew_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fifo_skew_ctrl
// Brief  : Diagonal-skew read scheduler for the systolic array's row FIFOs.
// Rev    : 1.0
// ============================================================================
module fifo_skew_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [ROWS-1:0]  i_fifo_empty,
    input  logic             i_array_ready,
    output logic [ROWS-1:0]  o_fifo_rd,
    output logic [ROWS-1:0]  o_row_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int STEP_W = step_w(LEN_W, ROWS);
    localparam logic [STEP_W-1:0] c_LAST_OFS = STEP_W'(ROWS - 2);

    state_e              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [STEP_W-1:0]   r_step;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic [STEP_W-1:0]   w_len_ext;
    logic [ROWS-1:0]     w_active;
    logic                w_blocked;
    logic                w_fire;
    logic                w_last;

    assign w_len_ext = STEP_W'(r_len);

    // Row r is due while r <= step < r + len.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign w_active[r] = (r_step >= STEP_W'(r)) &&
                             (r_step <  STEP_W'(r) + w_len_ext);
    end

    assign w_blocked = |(w_active & i_fifo_empty);
    assign w_fire    = (r_state == ST_RUN) && i_array_ready && !w_blocked;
    assign w_last    = (r_step == w_len_ext + c_LAST_OFS);

    // All due rows read together or none at all.
    assign o_fifo_rd   = w_fire ? w_active : '0;
    assign o_row_valid = o_fifo_rd;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_step      <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_len       <= i_len;
                        r_step      <= '0;
                        r_stall_cnt <= '0;
                        r_state     <= (i_len != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        r_step <= r_step + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end else if (r_stall_cnt != '1) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_skew_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_skew_ctrl
// Brief  : Scoreboard bench for fifo_skew_ctrl with directed job scenarios.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_skew_ctrl;

    localparam int ROWS  = 4;
    localparam int LEN_W = 8;
    localparam int CNT_W = 4;

    logic              i_clk         = 1'b0;
    logic              i_rstn        = 1'b0;
    logic              i_start       = 1'b0;
    logic [LEN_W-1:0]  i_len         = '0;
    logic [ROWS-1:0]   i_fifo_empty  = '0;
    logic              i_array_ready = 1'b1;
    logic [ROWS-1:0]   o_fifo_rd;
    logic [ROWS-1:0]   o_row_valid;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_stall_cnt;

    fifo_skew_ctrl #(.ROWS(ROWS), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .i_len         (i_len),
        .i_fifo_empty  (i_fifo_empty),
        .i_array_ready (i_array_ready),
        .o_fifo_rd     (o_fifo_rd),
        .o_row_valid   (o_row_valid),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_stall_cnt   (o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc  = 0;
    int base = 0;
    int checks   = 0;
    int failures = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        logic [ROWS-1:0] rd;
        logic            done;
        logic [CNT_W-1:0] st;
    } exp_t;

    exp_t q[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void exp_rd(input int c, input logic [ROWS-1:0] rd);
        q.push_back('{base + c, rd, 1'b0, '0});
    endfunction

    function automatic void exp_done(input int c, input logic [CNT_W-1:0] st);
        q.push_back('{base + c, '0, 1'b1, st});
    endfunction

    // Monitor: pops the scoreboard whenever the DUT reads or signals done.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            exp_t e;
            chk("row_valid_eq_rd", 32'(o_row_valid), 32'(o_fifo_rd));
            chk("no_empty_read", 32'(o_fifo_rd & i_fifo_empty), 32'd0);
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_output: nothing seen, expected rd=%b done=%b at cycle %0d", e.rd, e.done, e.cyc);
            end
            if (o_fifo_rd != '0 || o_done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got rd=%b done=%b expected none (cycle %0d)", o_fifo_rd, o_done, cyc);
                end else begin
                    e = q.pop_front();
                    chk("out_cycle", 32'(cyc), 32'(e.cyc));
                    chk("fifo_rd", 32'(o_fifo_rd), 32'(e.rd));
                    chk("done", 32'(o_done), 32'(e.done));
                    if (e.done) chk("stall_cnt_at_done", 32'(o_stall_cnt), 32'(e.st));
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_to(input int k);
        while (cyc < base + k) tick();
    endtask

    task automatic start_job(input int len);
        i_len   = LEN_W'(len);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        q.delete();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_fifo_rd", 32'(o_fifo_rd), 32'd0);
        chk("rst_row_valid", 32'(o_row_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_stall_cnt", 32'(o_stall_cnt), 32'd0);
        i_rstn = 1'b1;
        tick();

        // Nominal len=3
        base = cyc;
        exp_rd(1, 4'b0001); exp_rd(2, 4'b0011); exp_rd(3, 4'b0111);
        exp_rd(4, 4'b1110); exp_rd(5, 4'b1100); exp_rd(6, 4'b1000);
        exp_done(7, 4'd0);
        chk("nom_busy_c0", 32'(o_busy), 32'd0);
        start_job(3);
        chk("nom_busy_c1", 32'(o_busy), 32'd1);
        wait_to(7);
        chk("nom_busy_c7", 32'(o_busy), 32'd1);
        wait_to(8);
        chk("nom_busy_c8", 32'(o_busy), 32'd0);
        chk("nom_stall", 32'(o_stall_cnt), 32'd0);
        drain();

        // Row 2 empty in cycles 3-5
        base = cyc;
        exp_rd(1, 4'b0001); exp_rd(2, 4'b0011); exp_rd(6, 4'b0111);
        exp_rd(7, 4'b1110); exp_rd(8, 4'b1100); exp_rd(9, 4'b1000);
        exp_done(10, 4'd3);
        start_job(3);
        wait_to(3);
        i_fifo_empty = 4'b0100;
        wait_to(6);
        i_fifo_empty = 4'b0000;
        drain();
        chk("empty_stall_hold", 32'(o_stall_cnt), 32'd3);

        // Back-pressure in cycle 2; inactive row 3 empty at step 0
        base = cyc;
        exp_rd(1, 4'b0001); exp_rd(3, 4'b0011); exp_rd(4, 4'b0111);
        exp_rd(5, 4'b1110); exp_rd(6, 4'b1100); exp_rd(7, 4'b1000);
        exp_done(8, 4'd1);
        start_job(3);
        i_fifo_empty = 4'b1000;
        wait_to(2);
        i_fifo_empty  = 4'b0000;
        i_array_ready = 1'b0;
        wait_to(3);
        i_array_ready = 1'b1;
        drain();
        chk("bp_stall_hold", 32'(o_stall_cnt), 32'd1);

        // Zero-length job, second start while in DONE is ignored
        base = cyc;
        exp_done(1, 4'd0);
        start_job(0);
        i_start = 1'b1;
        wait_to(2);
        i_start = 1'b0;
        chk("len0_idle_c2", 32'(o_busy), 32'd0);
        wait_to(4);
        chk("len0_idle_c4", 32'(o_busy), 32'd0);
        drain();

        // Asynchronous reset during step 2
        base = cyc;
        exp_rd(1, 4'b0001); exp_rd(2, 4'b0011);
        start_job(3);
        wait_to(3);
        i_rstn = 1'b0;
        #1;
        chk("mid_rst_fifo_rd", 32'(o_fifo_rd), 32'd0);
        chk("mid_rst_row_valid", 32'(o_row_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_stall", 32'(o_stall_cnt), 32'd0);
        tick();
        #2;
        i_rstn = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_idle", 32'(o_busy), 32'd0);
        drain();

        base = cyc;
        exp_rd(1, 4'b0001); exp_rd(2, 4'b0010); exp_rd(3, 4'b0100);
        exp_rd(4, 4'b1000);
        exp_done(5, 4'd0);
        start_job(1);
        drain();

        // Stall counter saturation with a 4-bit counter
        base = cyc;
        exp_rd(21, 4'b0001); exp_rd(22, 4'b0010); exp_rd(23, 4'b0100);
        exp_rd(24, 4'b1000);
        exp_done(25, 4'd15);
        i_array_ready = 1'b0;
        start_job(1);
        wait_to(10);
        chk("sat_partial", 32'(o_stall_cnt), 32'd9);
        wait_to(20);
        chk("sat_value", 32'(o_stall_cnt), 32'd15);
        wait_to(21);
        i_array_ready = 1'b1;
        drain();
        wait_to(28);
        chk("sat_hold_after_done", 32'(o_stall_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
